// File: rtl/uart_tx_param_if.sv
// Handshake and serial-line bundle for uart_tx_param.
//   data_i  : word to send (DATA_BITS wide), sampled on accept
//   valid_i : source has a word on data_i
//   ready_o : transmitter idle; accept = valid_i & ready_o at posedge
//   tx_o    : serial line, idle high
//   busy_o  : frame in progress (= ~ready_o)
//   done_o  : one-cycle pulse in the cycle the transmitter returns to idle
// slave modport faces the transmitter, master modport faces the source.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_i;
  logic                 valid_i;
  logic                 ready_o;
  logic                 tx_o;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  data_i, valid_i,
    output ready_o, tx_o, busy_o, done_o
  );

  modport master (
    output data_i, valid_i,
    input  ready_o, tx_o, busy_o, done_o
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter.
// Serialises one word per valid/ready handshake into an async frame:
// start bit, DATA_BITS data bits LSB-first, optional parity bit, then
// STOP_BITS stop bits. Single clock domain, synchronous active-high reset.
// Ports:
//   clk_i   : system clock, rising edge
//   reset_i : synchronous active-high reset, aborts any frame in flight
//   bus     : uart_tx_param_if slave (data_i, valid_i, ready_o, tx_o,
//             busy_o, done_o)
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line high, ready for a word
// S_START  | start bit (line low) for CLKS_PER_BIT cycles
// S_DATA   | data bits LSB-first, one per CLKS_PER_BIT cycles
// S_PARITY | parity bit (only reachable when PARITY_EN != 0)
// S_STOP   | line high for STOP_BITS bit periods, then back to idle
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  uart_tx_param_if.slave bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  logic [BAUD_W-1:0]      r_baud;
  logic [BIT_W-1:0]       r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_tx;
  logic                   r_done;

  state_t                 w_state_n;
  logic [BAUD_W-1:0]      w_baud_n;
  logic [BIT_W-1:0]       w_bit_n;
  logic [DATA_BITS-1:0]   w_shift_n;
  logic                   w_par_n;
  logic                   w_tx_n;
  logic                   w_done_n;
  logic                   w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_done_n  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.valid_i) begin
          w_shift_n = bus.data_i;
          w_par_n   = (PARITY_ODD != 0) ? ~^bus.data_i : ^bus.data_i;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = S_DATA;
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_n  = '0;
          w_shift_n = r_shift >> 1;
          if (r_bit == DATA_LAST) begin
            w_bit_n   = '0;
            w_state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_n = r_bit + BIT_W'(1);
          end
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = S_STOP;
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_n = '0;
          if (r_bit == STOP_LAST) begin
            w_bit_n   = '0;
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
          end else begin
            w_bit_n = r_bit + BIT_W'(1);
          end
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Line level is derived from the next state so tx_o comes straight
    // from a flop and stays high across the stop -> idle boundary.
    unique case (w_state_n)
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_shift_n[0];
      S_PARITY: w_tx_n = w_par_n;
      default:  w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
      r_done  <= w_done_n;
    end
  end

  assign bus.ready_o = (r_state == S_IDLE);
  assign bus.busy_o  = (r_state != S_IDLE);
  assign bus.tx_o    = r_tx;
  assign bus.done_o  = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four instances with different frame
// formats. Stimulus pushes a hand-built expected frame (bit k = k-th bit on
// the line) per accepted word; a per-instance monitor detects the handshake,
// pops the frame and checks tx_o mid-bit, the busy window and the done cycle.
module tb_uart_tx_param;

  localparam int NI = 4;
  localparam int P_DB [NI] = '{8, 8, 8, 7};
  localparam int P_C  [NI] = '{16, 16, 5, 1};
  localparam int P_PE [NI] = '{0, 1, 1, 1};
  localparam int P_PO [NI] = '{0, 0, 1, 0};
  localparam int P_SB [NI] = '{1, 1, 1, 2};

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic [NI-1:0]  valid_a = '0;
  logic [8:0]     data_a [NI];
  logic [NI-1:0]  ready_v, tx_v, busy_v, done_v;

  logic [15:0]    exp_q [NI][$];
  int             exp_done [NI];
  int             done_cnt [NI];
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB = P_DB[g];
    localparam int C  = P_C[g];
    localparam int N  = (1 + DB + P_PE[g] + P_SB[g]) * C;

    uart_tx_param_if #(.DATA_BITS(DB)) ifc ();

    uart_tx_param #(
      .DATA_BITS   (DB),
      .CLKS_PER_BIT(C),
      .PARITY_EN   (P_PE[g]),
      .PARITY_ODD  (P_PO[g]),
      .STOP_BITS   (P_SB[g])
    ) u_dut (
      .clk_i  (clk),
      .reset_i(reset_i),
      .bus    (ifc.slave)
    );

    assign ifc.valid_i = valid_a[g];
    assign ifc.data_i  = data_a[g][DB-1:0];
    assign ready_v[g]  = ifc.ready_o;
    assign tx_v[g]     = ifc.tx_o;
    assign busy_v[g]   = ifc.busy_o;
    assign done_v[g]   = ifc.done_o;

    // Monitor: sampling on negedge, an accept is seen in the cycle before
    // the accepting edge; cycle j of the frame is the j-th negedge after it.
    initial begin : mon
      logic [15:0] fr;
      bit          active;
      bit          rst_pend;
      int          j;
      active   = 0;
      rst_pend = 0;
      j        = 0;
      fr       = '0;
      forever begin
        @(negedge clk);
        if (rst_pend) begin
          chk("after_reset", g, int'({ready_v[g], done_v[g], busy_v[g], tx_v[g]}), 'b1001);
          rst_pend = 0;
        end
        if (active) begin
          j++;
          if (j <= N) begin
            if ((j - 1) % C == C / 2)
              chk("tx_bit", g, int'(tx_v[g]), int'(fr[(j-1)/C]));
            chk("busy_window", g, int'({ready_v[g], done_v[g], busy_v[g]}), 'b001);
          end else begin
            chk("done_cycle", g, int'({ready_v[g], done_v[g], busy_v[g], tx_v[g]}), 'b1101);
            active = 0;
          end
          if (reset_i && active) begin
            active   = 0;
            rst_pend = 1;
          end
        end
        if (!active && !reset_i && valid_a[g] && ready_v[g]) begin
          if (exp_q[g].size() == 0) begin
            chk("unexpected_accept", g, 1, 0);
          end else begin
            fr     = exp_q[g].pop_front();
            active = 1;
            j      = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++)
      if (done_v[i] === 1'b1) done_cnt[i]++;
  end

  task automatic send(input int i, input logic [8:0] d, input logic [15:0] fr, input bit complete);
    int n;
    exp_q[i].push_back(fr);
    if (complete) exp_done[i]++;
    @(posedge clk); #1;
    valid_a[i] = 1'b1;
    data_a[i]  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready_v[i] !== 1'b1 && n < 3000);
    if (ready_v[i] !== 1'b1) chk("accept_timeout", i, 0, 1);
    @(posedge clk); #1;
    valid_a[i] = 1'b0;
    data_a[i]  = ~d;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    for (int i = 0; i < NI; i++) begin
      data_a[i]   = '0;
      exp_done[i] = 0;
      done_cnt[i] = 0;
    end
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk("in_reset", i, int'({ready_v[i], busy_v[i], done_v[i], tx_v[i]}), 'b1001);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk("reset_state", i, int'({ready_v[i], busy_v[i], done_v[i], tx_v[i]}), 'b1001);

    // 8N1, 16 clocks/bit
    send(0, 9'h0A5, 16'({1'b1, 8'hA5, 1'b0}), 1);

    // 8E1 and 8O1
    send(1, 9'h0A5, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 1);
    send(1, 9'h001, 16'({1'b1, 1'b1, 8'h01, 1'b0}), 1);
    send(2, 9'h0A5, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 1);
    send(2, 9'h000, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 1);

    // 7E2, one clock per bit
    send(3, 9'h041, 16'({2'b11, 1'b0, 7'h41, 1'b0}), 1);
    send(3, 9'h07F, 16'({2'b11, 1'b1, 7'h7F, 1'b0}), 1);

    // back-to-back: valid held, data switched in the done cycle
    exp_q[0].push_back(16'({1'b1, 8'h55, 1'b0}));
    exp_q[0].push_back(16'({1'b1, 8'h0F, 1'b0}));
    exp_done[0] += 2;
    n = 0;
    while (ready_v[0] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    valid_a[0] = 1'b1;
    data_a[0]  = 9'h055;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready_v[0] !== 1'b1 && n < 400);
    chk("b2b_ready_delay", 0, n, 161);
    data_a[0] = 9'h00F;
    @(posedge clk); #1;
    valid_a[0] = 1'b0;
    data_a[0]  = 9'h1AA;

    // reset mid-DATA of 0xFF, then a clean 0x00 frame
    send(0, 9'h0FF, 16'({1'b1, 8'hFF, 1'b0}), 0);
    repeat (70) @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    send(0, 9'h000, 16'({1'b1, 8'h00, 1'b0}), 1);

    // valid pulse while busy must be ignored
    send(0, 9'h03C, 16'({1'b1, 8'h3C, 1'b0}), 1);
    repeat (20) @(posedge clk);
    #1 valid_a[0] = 1'b1;
    data_a[0] = 9'h012;
    @(posedge clk); #1;
    valid_a[0] = 1'b0;

    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
          exp_q[3].size() == 0 && ready_v === '1)
        break;
    end
    chk("drain_timeout", 0, int'(n < 5000), 1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("done_count", i, done_cnt[i], exp_done[i]);
      chk("queue_empty", i, exp_q[i].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
